// File: rtl/enigma_stream_driver_pkg.sv
// Shared constants and state encoding for the Enigma host-side stream driver.
package enigma_stream_driver_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned DEF_DEPTH   = 4;
  localparam int unsigned DEF_TIMEOUT = 64;

  localparam logic [BYTE_W-1:0] ERR_BYTE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/enigma_stream_driver_fifo.sv
// Byte FIFO buffering host bytes ahead of the cipher core; DEPTH must be a power of 2.
module byte_fifo
  import enigma_stream_driver_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is not reset; an empty count is enough to discard contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/enigma_stream_driver.sv
// Host-side initiator for the Enigma core: buffers bytes, issues them one at a time,
// waits for done (or times out) and presents each result on a valid/ready port.
module enigma_stream_driver
  import enigma_stream_driver_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_load,
  input  logic              cfg_dec,
  input  logic              host_valid,
  input  logic [BYTE_W-1:0] host_data,
  output logic              host_ready,
  output logic              res_valid,
  output logic [BYTE_W-1:0] res_data,
  output logic              res_err,
  input  logic              res_ready,
  output logic              core_set,
  output logic              core_en,
  output logic              core_valid,
  output logic [BYTE_W-1:0] core_din,
  output logic              core_dec,
  input  logic [BYTE_W-1:0] core_dout,
  input  logic              core_done,
  output logic              busy
);

  localparam int unsigned   TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nx;
  logic              configured;
  logic              dec_q;
  logic [TW-1:0]     to_cnt;
  logic [BYTE_W-1:0] res_data_q;
  logic              res_err_q;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_head;

  assign fifo_push = host_valid && !fifo_full;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (host_data),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_nx = state;
    fifo_pop = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cfg_load)                       state_nx = ST_SET;
        else if (configured && !fifo_empty) state_nx = ST_ISSUE;
      end
      ST_SET:   state_nx = ST_IDLE;
      ST_ISSUE: begin
        fifo_pop = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done || (to_cnt == TO_LAST)) state_nx = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Decrypt mode is captured on the cycle cfg_load is accepted so it is already
  // stable while core_set strobes; done takes precedence over a same-cycle timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      configured <= 1'b0;
      dec_q      <= 1'b0;
      to_cnt     <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE:  if (cfg_load) dec_q <= cfg_dec;
        ST_SET:   configured <= 1'b1;
        ST_ISSUE: to_cnt <= '0;
        ST_WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (core_done) begin
            res_data_q <= core_dout;
            res_err_q  <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            res_data_q <= ERR_BYTE;
            res_err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign host_ready = !fifo_full;
  assign res_valid  = (state == ST_HOLD);
  assign res_data   = res_data_q;
  assign res_err    = res_err_q;
  assign core_set   = (state == ST_SET);
  assign core_en    = configured;
  assign core_valid = (state == ST_ISSUE);
  assign core_din   = (state == ST_ISSUE) ? fifo_head : '0;
  assign core_dec   = dec_q;
  assign busy       = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_enigma_stream_driver.sv
// Self-checking bench: a core model answers each issued byte with byte ^ 8'h1B after a
// per-byte delay (0 = never); expected results are queued at push time and compared on output.
module tb_enigma_stream_driver;

  logic       clk;
  logic       reset_n;
  logic       cfg_load;
  logic       cfg_dec;
  logic       host_valid;
  logic [7:0] host_data;
  logic       host_ready;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_err;
  logic       res_ready;
  logic       core_set;
  logic       core_en;
  logic       core_valid;
  logic [7:0] core_din;
  logic       core_dec;
  logic [7:0] core_dout;
  logic       core_done;
  logic       busy;

  enigma_stream_driver #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_load   (cfg_load),
    .cfg_dec    (cfg_dec),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_err    (res_err),
    .res_ready  (res_ready),
    .core_set   (core_set),
    .core_en    (core_en),
    .core_valid (core_valid),
    .core_din   (core_din),
    .core_dec   (core_dec),
    .core_dout  (core_dout),
    .core_done  (core_done),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0]  data;
    int unsigned delay;
    logic [7:0]  exp_data;
    logic        exp_err;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int issue_cnt = 0;
  int set_cnt   = 0;
  int res_cnt   = 0;
  int accept_issue_snap = 0;

  logic [8:0]  exp_res_q[$];
  logic [7:0]  exp_issue_q[$];
  int unsigned delay_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core model: counts issues/set strobes, checks issue order, answers after a delay.
  initial begin
    int unsigned cd;
    logic [7:0]  last_din;
    cd = 0;
    last_din = 8'h00;
    core_done = 1'b0;
    core_dout = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      if (!reset_n) begin
        cd = 0;
        continue;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          core_done = 1'b1;
          core_dout = last_din ^ 8'h1B;
        end
      end
      if (core_valid) begin
        issue_cnt++;
        check("issue_expected", exp_issue_q.size() != 0, 1);
        if (exp_issue_q.size() != 0) check("core_din", core_din, exp_issue_q.pop_front());
        last_din = core_din;
        cd = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
      end
      if (core_set) set_cnt++;
    end
  end

  // Result monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && res_valid && res_ready) begin
        res_cnt++;
        check("result_expected", exp_res_q.size() != 0, 1);
        if (exp_res_q.size() != 0) check("result", {res_err, res_data}, exp_res_q.pop_front());
      end
    end
  end

  task automatic push_byte(input logic [7:0] d, input int unsigned dly,
                           input logic [7:0] ed, input logic ee);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    host_valid = 1'b1;
    host_data  = d;
    @(negedge clk);
    while (!host_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("push_accept_bound", n < 300, 1);
    exp_issue_q.push_back(d);
    delay_q.push_back(dly);
    exp_res_q.push_back({ee, ed});
    accept_issue_snap = issue_cnt;
    @(posedge clk);
    #1;
    host_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_res_q.size() != 0) && n < lim) begin
      n++;
      @(negedge clk);
    end
    check(name, n < lim, 1);
  endtask

  task automatic wait_issue(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!core_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(name, n < 100, 1);
  endtask

  task automatic pulse_cfg(input logic dec);
    @(posedge clk);
    #1;
    cfg_load = 1'b1;
    cfg_dec  = dec;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   snap_i;
    int   snap_r;
    int   n;
    logic [7:0] b;

    tbl[0] = '{8'h00, 1,  8'h1B, 1'b0};
    tbl[1] = '{8'hFF, 2,  8'hE4, 1'b0};
    tbl[2] = '{8'h5A, 5,  8'h41, 1'b0};
    tbl[3] = '{8'hA5, 63, 8'hBE, 1'b0};
    tbl[4] = '{8'h3C, 64, 8'h27, 1'b0};
    tbl[5] = '{8'hC3, 65, 8'h00, 1'b1};
    tbl[6] = '{8'h7E, 0,  8'h00, 1'b1};
    tbl[7] = '{8'h81, 1,  8'h9A, 1'b0};

    reset_n    = 1'b0;
    cfg_load   = 1'b0;
    cfg_dec    = 1'b0;
    host_valid = 1'b0;
    host_data  = 8'h00;
    res_ready  = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_host_ready", host_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_core_en", core_en, 0);
    check("rst_core_set", core_set, 0);
    check("rst_core_valid", core_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_core_din", core_din, 0);
    check("rst_res", {res_err, res_data, core_dec}, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Bytes before configuration stay buffered; FIFO fills; 5th waits for the first pop
    for (int i = 0; i < 4; i++) begin
      b = 8'h41 + 8'(i);
      push_byte(b, 2, b ^ 8'h1B, 1'b0);
    end
    @(negedge clk);
    check("full_host_ready", host_ready, 0);
    check("unconf_busy", busy, 1);
    fork
      push_byte(8'h45, 2, 8'h45 ^ 8'h1B, 1'b0);
      begin
        repeat (3) @(negedge clk);
        check("no_issue_unconfigured", issue_cnt, 0);
        check("full_held", host_ready, 0);
        pulse_cfg(1'b0);
        @(negedge clk);
        check("set_strobe", core_set, 1);
        check("en_before_set_done", core_en, 0);
        @(negedge clk);
        check("set_one_cycle", core_set, 0);
        check("en_after_set", core_en, 1);
        check("dec_mode0", core_dec, 0);
      end
    join
    check("accept_after_pop", accept_issue_snap >= 1, 1);
    wait_drain("drain_order", 400);
    check("res_count_order", res_cnt, 5);
    check("set_count_first", set_cnt, 1);

    // Latency and result hold with a 3-cycle core
    res_ready = 1'b0;
    @(posedge clk);
    #1;
    host_valid = 1'b1;
    host_data  = 8'h41;
    exp_issue_q.push_back(8'h41);
    delay_q.push_back(3);
    exp_res_q.push_back({1'b0, 8'h5A});
    @(posedge clk);
    #1;
    host_valid = 1'b0;
    @(negedge clk);
    check("lat_idle_cycle", core_valid, 0);
    @(negedge clk);
    check("lat_issue", {core_valid, core_din}, {1'b1, 8'h41});
    @(negedge clk);
    check("lat_wait_din_zero", {core_valid, core_din}, 0);
    @(negedge clk);
    @(negedge clk);
    check("lat_no_early_res", res_valid, 0);
    @(negedge clk);
    check("lat_res", {res_valid, res_err, res_data}, {1'b1, 1'b0, 8'h5A});
    repeat (3) begin
      @(negedge clk);
      check("hold_stable", {res_valid, res_err, res_data}, {1'b1, 1'b0, 8'h5A});
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("res_valid_drop", res_valid, 0);
    check("latency_q_empty", exp_res_q.size(), 0);

    // Table-driven vectors incl. done-on-timeout-cycle and just-late done
    snap_r = res_cnt;
    for (int i = 0; i < 8; i++) push_byte(tbl[i].data, tbl[i].delay, tbl[i].exp_data, tbl[i].exp_err);
    wait_drain("drain_table", 1000);
    check("res_count_table", res_cnt - snap_r, 8);

    // Timeout: 64 WAIT cycles, late done during HOLD ignored
    res_ready = 1'b0;
    push_byte(8'h77, 70, 8'h00, 1'b1);
    wait_issue("to_issue");
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("timeout_cycles", n + 1, 65);
    repeat (8) begin
      @(negedge clk);
      check("timeout_hold", {res_valid, res_err, res_data}, {1'b1, 1'b1, 8'h00});
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_drain("drain_timeout", 50);
    push_byte(8'h78, 2, 8'h63, 1'b0);
    wait_drain("drain_after_timeout", 50);

    // cfg_load during WAIT is ignored; reconfigure in IDLE with decrypt
    snap_i = set_cnt;
    push_byte(8'h10, 12, 8'h0B, 1'b0);
    wait_issue("cfgwait_issue");
    pulse_cfg(1'b1);
    cfg_dec = 1'b0;
    wait_drain("drain_cfgwait", 100);
    check("no_set_in_wait", set_cnt, snap_i);
    check("dec_unchanged", core_dec, 0);
    pulse_cfg(1'b1);
    @(negedge clk);
    check("reset_set_strobe", core_set, 1);
    @(posedge clk);
    #1;
    cfg_dec = 1'b0;
    @(negedge clk);
    check("dec_mode1", core_dec, 1);
    check("set_count_dec", set_cnt, snap_i + 1);

    // Reset mid-WAIT with two bytes queued
    push_byte(8'h21, 40, 8'h3A, 1'b0);
    push_byte(8'h22, 40, 8'h39, 1'b0);
    push_byte(8'h23, 40, 8'h38, 1'b0);
    @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_outputs", {host_ready, res_valid, core_en, busy, core_valid}, 5'b10000);
    exp_issue_q.delete();
    delay_q.delete();
    exp_res_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    snap_i = issue_cnt;
    snap_r = res_cnt;
    repeat (50) @(negedge clk);
    check("post_rst_no_issue", issue_cnt, snap_i);
    check("post_rst_no_result", res_cnt, snap_r);
    check("post_rst_unconfigured", {core_en, busy}, 0);
    push_byte(8'h31, 2, 8'h2A, 1'b0);
    repeat (5) @(negedge clk);
    check("post_rst_wait_cfg", issue_cnt, snap_i);
    pulse_cfg(1'b0);
    wait_drain("drain_post_reset", 100);
    check("post_rst_result", res_cnt, snap_r + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
